fetch_unit: RTL and testbench

Instruction-fetch stage of the multicycle core, directly upstream of the controller. It owns the PC and the instruction register. On the controller's IRWrite strobe it runs a request/acknowledge read against instruction memory, then latches the returned word into Instr, whose bits [31:12] drive the controller's Instr input. It stalls the controller while a fetch is outstanding and flags a sticky error if memory never answers.

---
 rtl/fetch_unit.sv | 133 +++++++++++++
 tb/tb_fetch_unit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns PC and the instruction register, and runs a
// req/ack read to instruction memory with a sticky timeout.
module fetch_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}},
  parameter int               MAX_WAIT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PCWrite,
  input  logic [WIDTH-1:0] PCNext,
  input  logic             IRWrite,
  input  logic [WIDTH-1:0] MemRData,
  input  logic             MemAck,
  output logic             MemReq,
  output logic [WIDTH-1:0] MemAddr,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] Instr,
  output logic             InstrValid,
  output logic             Stall,
  output logic             FetchErr
);

  localparam int CW = $clog2(MAX_WAIT) + 1;
  localparam logic [CW-1:0] LAST_WAIT = CW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic             valid_q, valid_d;
  logic             req_q, req_d;
  logic             err_q, err_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             stall_s;

  // Next-state, register updates and the combinational stall request
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    valid_d = valid_q;
    req_d   = req_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    stall_s = 1'b0;
    case (state_q)
      IDLE: begin
        stall_s = IRWrite;
        if (PCWrite) begin
          pc_d = PCNext;
        end else begin
          pc_d = pc_q;
        end
        // Launch samples the pre-update PC even when PCWrite fires on the same edge
        if (IRWrite) begin
          addr_d  = pc_q;
          valid_d = 1'b0;
          cnt_d   = {CW{1'b0}};
          req_d   = 1'b1;
          state_d = REQ;
        end else begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      REQ: begin
        stall_s = ~MemAck;
        if (MemAck) begin
          instr_d = MemRData;
          valid_d = 1'b1;
          req_d   = 1'b0;
          state_d = IDLE;
        end else if (cnt_q == LAST_WAIT) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = ERR;
        end else begin
          cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      ERR: begin
        stall_s = 1'b1;
        req_d   = 1'b0;
        state_d = ERR;
      end
      default: begin
        stall_s = 1'b0;
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      instr_q <= {WIDTH{1'b0}};
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      req_q   <= req_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign MemReq     = req_q;
  assign MemAddr    = addr_q;
  assign PC         = pc_q;
  assign Instr      = instr_q;
  assign InstrValid = valid_q;
  assign FetchErr   = err_q;
  assign Stall      = stall_s;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed test-plan sequences plus random traffic,
// all checked cycle by cycle against a transaction-level fetch model.
module tb_fetch_unit;

  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        PCWrite = 1'b0;
  logic [31:0] PCNext = 32'd0;
  logic        IRWrite = 1'b0;
  logic [31:0] MemRData = 32'd0;
  logic        MemAck = 1'b0;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic [31:0] PC;
  logic [31:0] Instr;
  logic        InstrValid;
  logic        Stall;
  logic        FetchErr;

  int n_checks = 0;
  int n_fails  = 0;

  // model: a fetch is either outstanding, dead (error) or absent
  logic [31:0] m_pc = 32'd0, m_addr = 32'd0, m_instr = 32'd0;
  bit          m_valid = 1'b0, m_pending = 1'b0, m_dead = 1'b0;
  int          m_waited = 0;

  fetch_unit #(.WIDTH(32), .RESET_PC(32'h0000_0000), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset), .PCWrite(PCWrite), .PCNext(PCNext),
    .IRWrite(IRWrite), .MemRData(MemRData), .MemAck(MemAck),
    .MemReq(MemReq), .MemAddr(MemAddr), .PC(PC), .Instr(Instr),
    .InstrValid(InstrValid), .Stall(Stall), .FetchErr(FetchErr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc(input bit rst, input bit pcw, input logic [31:0] pcn,
                     input bit irw, input bit ack, input logic [31:0] rd);
    bit exp_stall;
    reset = rst; PCWrite = pcw; PCNext = pcn; IRWrite = irw; MemAck = ack; MemRData = rd;
    @(negedge clk);
    exp_stall = m_dead || (m_pending && !ack) || (!m_pending && !m_dead && irw);
    check_eq("Stall", 32'(Stall), 32'(exp_stall));
    if (rst) begin
      m_pc = 32'd0; m_addr = 32'd0; m_instr = 32'd0;
      m_valid = 1'b0; m_pending = 1'b0; m_dead = 1'b0; m_waited = 0;
    end else if (m_dead) begin
      m_dead = 1'b1;
    end else if (m_pending) begin
      m_waited++;
      if (ack) begin
        m_instr = rd; m_valid = 1'b1; m_pending = 1'b0;
      end else if (m_waited >= MAX_WAIT) begin
        m_pending = 1'b0; m_dead = 1'b1;
      end
    end else begin
      if (irw) begin
        m_addr = m_pc; m_valid = 1'b0; m_pending = 1'b1; m_waited = 0;
      end
      if (pcw) m_pc = pcn;
    end
    @(posedge clk);
    #1;
    check_eq("PC", PC, m_pc);
    check_eq("MemAddr", MemAddr, m_addr);
    check_eq("Instr", Instr, m_instr);
    check_eq("InstrValid", 32'(InstrValid), 32'(m_valid));
    check_eq("MemReq", 32'(MemReq), 32'(m_pending));
    check_eq("FetchErr", 32'(FetchErr), 32'(m_dead));
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    // reset held two cycles
    cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    check_eq("reset_pc", PC, 32'h0000_0000);
    check_eq("reset_stall", 32'(Stall), 32'd0);

    // normal fetch: launch with PCWrite, ack in third REQ cycle
    cyc(1'b0, 1'b1, 32'd4, 1'b1, 1'b0, 32'd0);
    check_eq("launch_addr", MemAddr, 32'd0);
    check_eq("launch_pc", PC, 32'd4);
    idle_cyc();
    idle_cyc();
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'hE04F_000F);
    check_eq("normal_instr", Instr, 32'hE04F_000F);

    // zero-wait fetch, then back-to-back launch at PC=4
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h1234_5678);
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    check_eq("b2b_addr", MemAddr, 32'd4);
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0BAD_F00D);

    // branch in IDLE, ignored PCWrite during REQ
    cyc(1'b0, 1'b1, 32'd40, 1'b0, 1'b0, 32'd0);
    check_eq("branch_pc", PC, 32'd40);
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    cyc(1'b0, 1'b1, 32'd80, 1'b1, 1'b0, 32'd0);
    check_eq("req_pc_hold", PC, 32'd40);
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'hCAFE_0001);

    // timeout with no ack; inputs ignored afterwards
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < MAX_WAIT; i++) idle_cyc();
    check_eq("timeout_err", 32'(FetchErr), 32'd1);
    cyc(1'b0, 1'b1, 32'd100, 1'b1, 1'b1, 32'hFFFF_FFFF);
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);

    // ack in the final allowed REQ cycle wins
    cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < MAX_WAIT - 1; i++) idle_cyc();
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h5A5A_A5A5);
    check_eq("late_ack_noerr", 32'(FetchErr), 32'd0);

    // reset mid-fetch, then a stray ack
    cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    idle_cyc();
    cyc(1'b1, 1'b1, 32'd8, 1'b0, 1'b1, 32'h1111_1111);
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h2222_2222);
    check_eq("rst_mid_instr", Instr, 32'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(39) == 0), ($urandom_range(2) == 0), {$urandom} & 32'hFFFF_FFFC,
          ($urandom_range(1) == 0), ($urandom_range(2) == 0), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
